ps2_host_rx: RTL and testbench
==============================

Name: ps2_host_rx

Overview:
- PS/2 host-side receiver: deserialises device-to-host frames (mouse/keyboard) from the open-collector ps2_clk/ps2_data lines.
- Sits beside the host transmitter in the mouse interface; rx_en is driven from the transmitter's ready flag so receive is inhibited while the host owns the bus.
- Delivers one byte per frame with a single-cycle valid strobe plus parity, framing and timeout error flags.

Parameters:
- FILTER_LEN, 8, number of consecutive identical synchronised ps2_clk samples required before the filtered clock changes (range 2..15).
- TIMEOUT_BITS, 13, width of the inter-edge watchdog counter; timeout after 2^TIMEOUT_BITS-1 clk cycles without a filtered falling edge mid-frame.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ps2_clk_in  in  1  raw PS/2 clock line (asynchronous)
- ps2_data_in  in  1  raw PS/2 data line (asynchronous)
- rx_en  in  1  1 = receive allowed; 0 = abort any frame and hold IDLE
- rx_data  out  8  last received byte, LSB = first data bit on wire
- rx_valid  out  1  one-cycle strobe, rx_data updated and frame good
- rx_parity_err  out  1  one-cycle strobe, odd parity check failed
- rx_frame_err  out  1  one-cycle strobe, start bit not 0 or stop bit not 1
- rx_timeout_err  out  1  one-cycle strobe, frame abandoned by watchdog
- rx_busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst_n low, async): all state cleared; rx_data=8'h00, all strobes 0, rx_busy=0, sync flops and filtered clock = 1, state IDLE.
- Input path: ps2_clk_in and ps2_data_in each pass through 2-flop synchronisers, reset value 1.
- Glitch filter: counter tracks the synchronised clock; filtered clock takes the new value only after FILTER_LEN consecutive equal samples differing from the current filtered value; shorter pulses are ignored.
- fall = filtered clock registered 1 -> 0 (one-cycle pulse). Data is sampled from the synchronised data in the same cycle as fall.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0 -> DATA, bit count=0, watchdog loaded. fall with data=1 -> rx_frame_err strobe, stay IDLE.
  - DATA: on fall shift data into shift register from MSB side (LSB-first wire order); after the 8th bit -> PARITY.
  - PARITY: on fall capture parity bit -> STOP.
  - STOP: on fall evaluate. Stop=0 -> rx_frame_err. Else if ^{data,parity} != 1 -> rx_parity_err. Else rx_valid and rx_data load. Always -> IDLE.
- Only one of rx_valid/rx_parity_err/rx_frame_err asserts per frame. rx_data changes only with rx_valid.
- Latency: each strobe is registered, high for exactly the one clk cycle after the cycle in which the stop-bit fall occurs.
- Watchdog: loaded to all-ones on entering DATA and on every fall in DATA/PARITY/STOP; decrements otherwise. On reaching 0 outside IDLE -> rx_timeout_err strobe, -> IDLE, partial data discarded.
- rx_en=0: state forced to IDLE next cycle, no strobes; falls are ignored while rx_en=0. A frame in progress when rx_en rises is not resumed; reception restarts on the next start bit.
- Simultaneous watchdog expiry and fall in the same cycle: fall wins (watchdog reload).
- No back-pressure: a consumer missing a strobe loses the byte; rx_data holds until the next good frame.

Test Plan:
- Device sends 0xA5, parity 1, stop 1 at 12.5 kHz, clk 50 MHz -> exactly one rx_valid, rx_data=8'hA5, no error strobes, rx_busy high start->stop+1.
- Device sends 0x00 with parity 0 -> rx_parity_err one cycle, rx_valid 0, rx_data keeps previous 8'hA5.
- Device sends 0x3C, parity 1, stop 0 -> rx_frame_err one cycle, no rx_valid.
- Device stops clocking after the 4th data bit -> rx_timeout_err 8191 (+/- sync/filter latency) cycles after the last fall, state IDLE. A following full 0xF4 frame is received correctly.
- 3-cycle low glitches injected on ps2_clk_in during a 0xFA frame (FILTER_LEN=8) -> ignored, rx_data=8'hFA, rx_valid once.
- rx_en dropped mid-frame for 10 cycles, then raised -> no strobes for that frame. The next 0xAA frame is received correctly. Assert rst_n low mid-frame -> outputs return to reset values immediately.

Source files
------------

// File: rtl/ps2_host_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_host_rx : PS/2 device-to-host frame receiver with glitch filter,     |
// | parity/framing checks and inter-edge watchdog.            Revision 1.0   |
// +--------------------------------------------------------------------------+
module ps2_host_rx #(
   parameter int FILTER_LEN   = 8,
   parameter int TIMEOUT_BITS = 13
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   input  logic       rx_en,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_parity_err,
   output logic       rx_frame_err,
   output logic       rx_timeout_err,
   output logic       rx_busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   localparam logic [3:0]              C_FILT_LAST = 4'(FILTER_LEN - 1);
   localparam logic [TIMEOUT_BITS-1:0] C_WD_MAX    = '1;

   logic                    clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic                    filt_q, filt_dly_q;
   logic [3:0]              fcnt_q;
   logic                    fall_w;

   state_t                  state_q, state_d;
   logic [2:0]              bitcnt_q, bitcnt_d;
   logic [7:0]              shift_q, shift_d;
   logic                    par_q, par_d;
   logic [TIMEOUT_BITS-1:0] wd_q, wd_d;
   logic [7:0]              data_q, data_d;
   logic                    valid_q, valid_d;
   logic                    perr_q, perr_d;
   logic                    ferr_q, ferr_d;
   logic                    tout_q, tout_d;

   // Filtered clock only moves after FILTER_LEN consecutive disagreeing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
         filt_q     <= 1'b1;
         filt_dly_q <= 1'b1;
         fcnt_q     <= 4'd0;
      end else begin
         clk_s1_q   <= ps2_clk_in;
         clk_s2_q   <= clk_s1_q;
         dat_s1_q   <= ps2_data_in;
         dat_s2_q   <= dat_s1_q;
         filt_dly_q <= filt_q;
         if (clk_s2_q == filt_q) begin
            fcnt_q <= 4'd0;
         end else if (fcnt_q == C_FILT_LAST) begin
            filt_q <= clk_s2_q;
            fcnt_q <= 4'd0;
         end else begin
            fcnt_q <= fcnt_q + 4'd1;
         end
      end
   end

   assign fall_w = filt_dly_q & ~filt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         bitcnt_q <= 3'd0;
         shift_q  <= 8'h00;
         par_q    <= 1'b0;
         wd_q     <= '0;
         data_q   <= 8'h00;
         valid_q  <= 1'b0;
         perr_q   <= 1'b0;
         ferr_q   <= 1'b0;
         tout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         wd_q     <= wd_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         perr_q   <= perr_d;
         ferr_q   <= ferr_d;
         tout_q   <= tout_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
      par_d    = par_q;
      wd_d     = wd_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      perr_d   = 1'b0;
      ferr_d   = 1'b0;
      tout_d   = 1'b0;
      if (!rx_en) begin
         state_d = S_IDLE;
      end else if (state_q == S_IDLE) begin
         if (fall_w) begin
            if (!dat_s2_q) begin
               state_d  = S_DATA;
               bitcnt_d = 3'd0;
               wd_d     = C_WD_MAX;
            end else begin
               ferr_d = 1'b1;
            end
         end
      end else if (fall_w) begin
         // A fall in the same cycle as watchdog expiry reloads instead of timing out.
         wd_d = C_WD_MAX;
         case (state_q)
            S_DATA: begin
               shift_d  = {dat_s2_q, shift_q[7:1]};
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) state_d = S_PARITY;
            end
            S_PARITY: begin
               par_d   = dat_s2_q;
               state_d = S_STOP;
            end
            default: begin
               state_d = S_IDLE;
               if (!dat_s2_q) begin
                  ferr_d = 1'b1;
               end else if (^{shift_q, par_q} != 1'b1) begin
                  perr_d = 1'b1;
               end else begin
                  valid_d = 1'b1;
                  data_d  = shift_q;
               end
            end
         endcase
      end else if (wd_q == '0) begin
         tout_d  = 1'b1;
         state_d = S_IDLE;
      end else begin
         wd_d = wd_q - 1'b1;
      end
   end

   assign rx_data        = data_q;
   assign rx_valid       = valid_q;
   assign rx_parity_err  = perr_q;
   assign rx_frame_err   = ferr_q;
   assign rx_timeout_err = tout_q;
   assign rx_busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ps2_host_rx : randomized self-checking bench for ps2_host_rx against  |
// | a frame-level outcome model.                              Revision 1.0   |
// +--------------------------------------------------------------------------+
module tb_ps2_host_rx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ps2_clk_in = 1'b1;
   logic       ps2_data_in = 1'b1;
   logic       rx_en = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid, rx_parity_err, rx_frame_err, rx_timeout_err, rx_busy;

   ps2_host_rx #(.FILTER_LEN(8), .TIMEOUT_BITS(13)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ps2_clk_in     (ps2_clk_in),
      .ps2_data_in    (ps2_data_in),
      .rx_en          (rx_en),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .rx_parity_err  (rx_parity_err),
      .rx_frame_err   (rx_frame_err),
      .rx_timeout_err (rx_timeout_err),
      .rx_busy        (rx_busy)
   );

   always #10 clk = ~clk;

   int         total = 0;
   int         bad = 0;
   int         n_v = 0, n_p = 0, n_f = 0, n_t = 0, n_multi = 0, n_dchg = 0;
   logic [7:0] last_data = 8'h00;
   logic [7:0] prev_data = 8'h00;
   logic [7:0] exp_data = 8'h00;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_valid) begin
            n_v++;
            last_data = rx_data;
         end
         if (rx_parity_err)  n_p++;
         if (rx_frame_err)   n_f++;
         if (rx_timeout_err) n_t++;
         if (32'(rx_valid) + 32'(rx_parity_err) + 32'(rx_frame_err) + 32'(rx_timeout_err) > 1)
            n_multi++;
         if (rx_data !== prev_data && !rx_valid) n_dchg++;
      end
      prev_data = rx_data;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Frame outcome from the wire bits: 0 good, 1 parity error, 2 framing error.
   function automatic int outcome(input logic [7:0] d, input logic p, input logic s);
      if (s == 1'b0) return 2;
      if (($countones({d, p}) % 2) != 1) return 1;
      return 0;
   endfunction

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int hp,
                             input bit glitch, input bit bchk, input int drop_bit,
                             input int stop_after, input logic st);
      logic [10:0] bits;
      bits = {s, p, d, st};
      for (int i = 0; i < 11; i++) begin
         if (i == stop_after) break;
         if (bchk && i == 9) chk("busy_mid", rx_busy, 1);
         ps2_data_in = bits[i];
         cyc(hp / 2);
         ps2_clk_in = 1'b0;
         if (i == drop_bit) begin
            cyc(5);
            rx_en = 1'b0;
            cyc(3);
            chk("busy_rxen_low", rx_busy, 0);
            cyc(7);
            rx_en = 1'b1;
            cyc(hp - 15);
         end else begin
            cyc(hp);
         end
         ps2_clk_in = 1'b1;
         if (glitch) begin
            cyc(hp / 4);
            ps2_clk_in = 1'b0;
            cyc(3);
            ps2_clk_in = 1'b1;
            cyc(hp / 2 - hp / 4 - 3);
         end else begin
            cyc(hp / 2);
         end
      end
      ps2_data_in = 1'b1;
   endtask

   task automatic run_frame(input string tag, input logic [7:0] d, input logic p, input logic s,
                            input int hp, input bit glitch, input bit bchk);
      int v0, p0, f0, t0, o;
      v0 = n_v; p0 = n_p; f0 = n_f; t0 = n_t;
      send_frame(d, p, s, hp, glitch, bchk, -1, 11, 1'b0);
      cyc(20);
      o = outcome(d, p, s);
      if (o == 0) exp_data = d;
      chk({tag, "_valid"}, n_v - v0, (o == 0) ? 1 : 0);
      chk({tag, "_perr"},  n_p - p0, (o == 1) ? 1 : 0);
      chk({tag, "_ferr"},  n_f - f0, (o == 2) ? 1 : 0);
      chk({tag, "_tout"},  n_t - t0, 0);
      chk({tag, "_data"},  rx_data, exp_data);
      chk({tag, "_idle"},  rx_busy, 0);
   endtask

   initial begin
      int v0, p0, f0, t0, c, lat, hp, kind;
      logic [7:0] d;
      logic       p, s;

      cyc(5);
      chk("rst_data", rx_data, 8'h00);
      chk("rst_strobes", {rx_valid, rx_parity_err, rx_frame_err, rx_timeout_err}, 4'b0000);
      chk("rst_busy", rx_busy, 0);
      rst_n = 1'b1;
      cyc(10);

      run_frame("a5", 8'hA5, 1'b1, 1'b1, 40, 1'b0, 1'b1);
      chk("a5_captured", last_data, 8'hA5);
      run_frame("par", 8'h00, 1'b0, 1'b1, 40, 1'b0, 1'b0);
      run_frame("stop", 8'h3C, 1'b1, 1'b0, 40, 1'b0, 1'b0);

      v0 = n_v; p0 = n_p; f0 = n_f; t0 = n_t; c = 0;
      send_frame(8'h5B, 1'b0, 1'b1, 20, 1'b0, 1'b0, -1, 5, 1'b0);
      while (n_t == t0 && c < 9000) begin
         cyc(1);
         c++;
      end
      lat = c + 30;
      chk("tout_seen", n_t - t0, 1);
      chk("tout_window", (lat >= 8191 && lat <= 8215), 1);
      chk("tout_idle", rx_busy, 0);
      chk("tout_other", (n_v - v0) + (n_p - p0) + (n_f - f0), 0);
      cyc(10);
      run_frame("f4", 8'hF4, 1'b0, 1'b1, 40, 1'b0, 1'b0);

      run_frame("glitch", 8'hFA, 1'b1, 1'b1, 40, 1'b1, 1'b0);

      f0 = n_f;
      send_frame(8'h00, 1'b0, 1'b1, 30, 1'b0, 1'b0, -1, 1, 1'b1);
      cyc(20);
      chk("lone_start_ferr", n_f - f0, 1);
      chk("lone_start_idle", rx_busy, 0);

      for (int i = 0; i < 16; i++) begin
         hp   = $urandom_range(16, 60);
         d    = 8'($urandom);
         kind = $urandom_range(0, 9);
         s    = (kind < 8);
         p    = (kind >= 6 && kind < 8) ? ^d : ~^d;
         run_frame($sformatf("rnd%0d", i), d, p, s, hp, ($urandom_range(0, 3) == 0), 1'b0);
      end

      v0 = n_v; p0 = n_p; f0 = n_f; t0 = n_t;
      d = 8'($urandom);
      send_frame(d, ~^d, 1'b1, 40, 1'b0, 1'b0, 10, 11, 1'b0);
      cyc(20);
      chk("rxen_no_strobes", (n_v - v0) + (n_p - p0) + (n_f - f0) + (n_t - t0), 0);
      chk("rxen_data_hold", rx_data, exp_data);
      run_frame("aa", 8'hAA, 1'b1, 1'b1, 40, 1'b0, 1'b0);

      fork
         send_frame(8'h55, 1'b1, 1'b1, 40, 1'b0, 1'b0, -1, 11, 1'b0);
         begin
            cyc(240);
            #3 rst_n = 1'b0;
            #1;
            chk("midrst_data", rx_data, 8'h00);
            chk("midrst_busy", rx_busy, 0);
            chk("midrst_strobes", {rx_valid, rx_parity_err, rx_frame_err, rx_timeout_err}, 4'b0000);
         end
      join
      cyc(5);
      rst_n = 1'b1;
      exp_data = 8'h00;
      cyc(20);
      run_frame("post_rst", 8'h96, 1'b1, 1'b1, 30, 1'b0, 1'b0);

      chk("one_strobe_per_cycle", n_multi, 0);
      chk("data_only_with_valid", n_dchg, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
